// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Define RV_MULDIV_DIV_EN to build the divider; without it, divide ops complete immediately with r = 0.
module rv_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] r
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     hi, lo, mcand;
    logic                neg;
    logic [CW-1:0]       cnt;

    logic                accept, bypass;
    logic                sa, sb, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     result;
`ifdef RV_MULDIV_DIV_EN
    logic                div_zero, div_ovf;
    logic [XLEN:0]       div_shift, div_diff;
`endif

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        logic signed [XLEN-1:0] s;
        s = $signed(v);
        return n ? $unsigned(-s) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
        logic signed [2*XLEN-1:0] s;
        s = $signed(v);
        return n ? $unsigned(-s) : v;
    endfunction

    // Operand decode: which inputs are signed for this op, and their magnitudes
    always_comb begin
        accept = start && !flush && (state == IDLE || state == DONE);
        sa     = op[2] ? !op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        sb     = op[2] ? !op[0] : (op[1:0] == 2'b01);
        a_neg  = sa && a[XLEN-1];
        b_neg  = sb && b[XLEN-1];
        a_mag  = cond_neg(a, a_neg);
        b_mag  = cond_neg(b, b_neg);
`ifdef RV_MULDIV_DIV_EN
        div_zero = (b == '0);
        div_ovf  = !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        bypass   = op[2] && (div_zero || div_ovf);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand};
`else
        bypass   = op[2];
`endif
        mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? mcand : '0)};
        prod_fix = cond_neg2({hi, lo}, neg);
    end

    always_comb begin
        result = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        if (op_q[2]) begin
`ifdef RV_MULDIV_DIV_EN
            result = op_q[1] ? cond_neg(hi, neg) : cond_neg(lo, neg);
`else
            result = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = bypass ? FIX : CALC;
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = accept ? (bypass ? FIX : CALC) : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Datapath: hi:lo is the product for multiply, remainder:quotient for divide
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            r     <= '0;
        end else if (accept) begin
            op_q <= op;
            cnt  <= '0;
            hi   <= '0;
            if (!op[2]) begin
                lo    <= b_mag;
                mcand <= a_mag;
                neg   <= a_neg ^ b_neg;
`ifdef RV_MULDIV_DIV_EN
            end else if (div_zero) begin
                hi    <= a;
                lo    <= '1;
                mcand <= b;
                neg   <= 1'b0;
            end else if (div_ovf) begin
                lo    <= a;
                mcand <= b;
                neg   <= 1'b0;
            end else begin
                lo    <= a_mag;
                mcand <= b_mag;
                neg   <= op[1] ? a_neg : (a_neg ^ b_neg);
`endif
            end else begin
                lo    <= '0;
                mcand <= '0;
                neg   <= 1'b0;
            end
        end else if (state == CALC) begin
            cnt <= cnt + CW'(1);
`ifdef RV_MULDIV_DIV_EN
            if (op_q[2]) begin
                if (!div_diff[XLEN]) begin
                    hi <= div_diff[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b1};
                end else begin
                    hi <= div_shift[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b0};
                end
            end else
`endif
            begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
        end else if (state == FIX && !flush) begin
            r <= result;
        end
    end

endmodule

// File: tb/tb_rv_muldiv.sv
// Randomized self-checking bench for rv_muldiv (XLEN=32) against an arithmetic reference model.
module tb_rv_muldiv;

    localparam int XLEN = 32;
`ifdef RV_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] r;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_r = '0;

    always #5 clk = ~clk;

    rv_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .op(op), .a(a), .b(b), .busy(busy), .done(done), .r(r)
    );

    localparam logic [2:0]  DF [13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4};
    localparam logic [31:0] DX [13] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                        32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                        32'h80000000, 32'h80000000, 32'd6};
    localparam logic [31:0] DY [13] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                        32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3};
    localparam logic [31:0] DE [13] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF,
                                        32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0000000E, 32'h00000002,
                                        32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h00000000, 32'h00000002};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        longint unsigned pu;
        logic [31:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'(x);
        uy = longint'(y);
        pu = longint'(unsigned'(ux)) * longint'(unsigned'(uy));
        res = '0;
        case (f)
            3'd0: begin p = sx * sy; res = p[31:0]; end
            3'd1: begin p = sx * sy; res = p[63:32]; end
            3'd2: begin p = sx * uy; res = p[63:32]; end
            3'd3: res = pu[63:32];
            3'd4: begin if (y == 0) res = '1; else begin p = sx / sy; res = p[31:0]; end end
            3'd5: begin if (y == 0) res = '1; else begin p = ux / uy; res = p[31:0]; end end
            3'd6: begin if (y == 0) res = x; else begin p = sx % sy; res = p[31:0]; end end
            default: begin if (y == 0) res = x; else begin p = ux % uy; res = p[31:0]; end end
        endcase
        if (f[2] && !DIV_EN) res = '0;
        return res;
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (!f[2]) return XLEN + 1;
        if (!DIV_EN || y == 0) return 1;
        if (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
        return XLEN + 1;
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        op = f;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_r);
        int n = 0;
        while (n < 100) begin
            n++;
            tick();
            if (done) break;
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_r"}, r, exp_r);
        last_r = exp_r;
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_r);
        issue(f, x, y);
        wait_done(tag, lat_of(f, x, y), exp_r);
        tick();
        check({tag, "_pulse"}, done, 0);
    endtask

    task automatic quiet(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check({tag, "_no_done"}, seen, 0);
        check({tag, "_r_held"}, r, last_r);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] x, y, e;

        rst = 1'b0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_r", r, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            e = (DF[i][2] && !DIV_EN) ? 32'd0 : DE[i];
            run($sformatf("dir%0d", i), DF[i], DX[i], DY[i], e);
        end

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            x = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = $urandom_range(1, 15);
                2: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                default: y = $urandom;
            endcase
            run($sformatf("rnd%0d_op%0d", i, f), f, x, y, model(f, x, y));
        end

        run("pre_flush", 3'd3, 32'hDEADBEEF, 32'h12345678, model(3'd3, 32'hDEADBEEF, 32'h12345678));
        issue(3'd0, 32'd7, 32'd9);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        quiet("flush");

        op = 3'd0; a = 32'd3; b = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("start_flush_busy", busy, 0);
        quiet("start_flush");

        run("pre_reset", 3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
        issue(DIV_EN ? 3'd4 : 3'd0, 32'd1000, 32'd7);
        repeat (19) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midop_reset_busy", busy, 0);
        check("midop_reset_done", done, 0);
        check("midop_reset_r", r, 0);
        last_r = '0;
        quiet("midop_reset");

        issue(3'd0, 32'h00001234, 32'h00005678);
        repeat (5) tick();
        op = 3'd3; a = $urandom; b = $urandom;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ignored_start_busy", busy, 1);
        wait_done("ignored_start", XLEN + 1 - 6, model(3'd0, 32'h00001234, 32'h00005678));
        tick();
        check("ignored_start_pulse", done, 0);

        issue(3'd1, 32'h89ABCDEF, 32'h76543210);
        wait_done("b2b_first", XLEN + 1, model(3'd1, 32'h89ABCDEF, 32'h76543210));
        issue(3'd4, 32'd6, 32'd3);
        check("b2b_done_drop", done, 0);
        wait_done("b2b_second", lat_of(3'd4, 32'd6, 32'd3), model(3'd4, 32'd6, 32'd3));
        issue(3'd2, 32'hF0000001, 32'h0000FFFF);
        wait_done("b2b_third", XLEN + 1, model(3'd2, 32'hF0000001, 32'h0000FFFF));
        tick();
        check("b2b_pulse", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
